mux_channel_scanner: RTL and testbench
======================================

// Module: mux_channel_scanner
// PURPOSE
//   Upstream sequencer for the gate-level MUX_4x1. On a START pulse it steps the mux select
//   lines {S1,S2} through channels 0..3 and holds each channel for DWELL clocks. At the end
//   of each dwell it captures the mux output (MUX_OUT) into a 4-bit SAMPLES register. It
//   then reports completion with a one-cycle DONE pulse. This lets system logic read all four
//   mux inputs without driving the selects by hand.
// PARAMETERS
//   DWELL  4  clocks each channel is held; sample taken on last clock; legal range 2..255
//   CONT   0  1 = restart scan automatically after DONE; 0 = return to IDLE
// PORTS
//   CLK      input   1  system clock; all state changes on rising edge
//   RST_N    input   1  asynchronous, active-low reset
//   START    input   1  scan request; sampled only in IDLE
//   MUX_OUT  input   1  OUT of the downstream MUX_4x1
//   S1       output  1  mux select MSB (channel index bit 1)
//   S2       output  1  mux select LSB (channel index bit 0)
//   BUSY     output  1  high while a scan is in progress (state SCAN)
//   DONE     output  1  one-cycle pulse: SAMPLES is complete and stable
//   SAMPLES  output  4  SAMPLES[i] = MUX_OUT captured while channel i was selected
// BEHAVIOUR
//   Interface
//   - One clock, CLK. Reset RST_N is asynchronous and active-low.
//   - RST_N low forces, immediately: state=IDLE, S1=0, S2=0, BUSY=0, DONE=0,
//     SAMPLES=4'b0000, dwell counter=0.
//   - Channel index ch = {S1,S2}: 00=I0, 01=I1, 10=I2, 11=I3.
//   - All outputs are registered; none depends combinationally on inputs.
//   State machine: IDLE -> SCAN -> DONE -> IDLE (or -> SCAN when CONT=1)
//   - IDLE: S1=S2=0, BUSY=0. On an edge with START=1:
//     go to SCAN, ch=0, cnt=DWELL-1, BUSY=1.
//   - SCAN, each edge:
//     - if cnt!=0: cnt=cnt-1; ch held.
//     - if cnt==0: SAMPLES[ch] <= MUX_OUT.
//       - If ch!=3: ch=ch+1, cnt=DWELL-1.
//       - If ch==3: go to DONE, BUSY=0, DONE=1, ch held at 3.
//   - DONE lasts exactly one cycle, with S1=S2=1 held.
//     - CONT=0: next edge goes to IDLE; S1=S2=0, DONE=0.
//     - CONT=1: next edge goes to SCAN with ch=0, cnt=DWELL-1, BUSY=1, DONE=0.
//   Latency: with START sampled at edge k, the sample edges are k+DWELL*(i+1) for i=0..3.
//     DONE is high from edge k+4*DWELL to edge k+4*DWELL+1.
//   Boundary cases
//   - START while in SCAN or DONE is ignored; it is not queued.
//   - START held high in IDLE starts exactly one scan. With CONT=0 the block returns to IDLE
//     after DONE; a still-high START then begins a new scan on the following edge.
//   - SAMPLES bits not yet refreshed in the current scan keep their previous-scan values.
//     SAMPLES bits are written only on sample edges.
//   - RST_N asserted mid-scan aborts it at once and clears all state, including SAMPLES.
//     The first START after release begins at channel 0.
//   - The counter is 8 bits. DWELL<2 is illegal: the mux gate delays need at least one full
//     settle cycle before sampling.
// TESTING
//   1. Reset: RST_N=0 mid-scan -> S1,S2,BUSY,DONE=0 and SAMPLES=0 immediately, without waiting
//      for a clock edge.
//   2. Basic scan, DWELL=4, CONT=0, mux I0..I3=1,0,1,0, START pulse at edge 0:
//      - {S1,S2}=00,01,10,11 for 4 clocks each;
//      - DONE high only at edge 16; SAMPLES=4'b0101; IDLE afterwards.
//   3. Inverse pattern I0..I3=0,1,1,1, second scan after scenario 2 -> SAMPLES=4'b1110.
//      BUSY is high for 16 cycles.
//   4. START re-pulsed at edges 3 and 9 during a scan -> no restart; DONE still at edge 16.
//   5. CONT=1, DWELL=2 -> DONE pulses every 9 cycles (edges 8, 17, 26). While DONE is high,
//      {S1,S2}=11, and it returns to 00 on the next edge.
//   6. START held high, CONT=0 -> back-to-back scans, each with a one-cycle DONE followed by
//      a one-cycle IDLE. Changing I2 mid-run updates only SAMPLES[2] at its next sample edge.

Source files
------------

// File: rtl/mux_channel_scanner_if.sv
// Bundle of the scan request, mux feedback and scan results between the
// system logic (master) and the channel scanner (slave).
interface mux_channel_scanner_if;
    logic       start;
    logic       mux_out;
    logic       s1;
    logic       s2;
    logic       busy;
    logic       done;
    logic [3:0] samples;

    modport master (
        output start,
        output mux_out,
        input  s1,
        input  s2,
        input  busy,
        input  done,
        input  samples
    );

    modport slave (
        input  start,
        input  mux_out,
        output s1,
        output s2,
        output busy,
        output done,
        output samples
    );
endinterface

// File: rtl/mux_channel_scanner.sv
// Sequencer for a 4:1 mux: walks the selects through channels 0..3, holds
// each for DWELL clocks, samples the mux output on the last clock of each
// dwell and flags completion with a single-cycle done pulse.
module mux_channel_scanner #(
    parameter int DWELL = 4,
    parameter bit CONT  = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_channel_scanner_if.slave bus
);

    // Reload value for the 8-bit dwell counter; DWELL must be 2..255 so the
    // mux gates have at least one full settle cycle before sampling.
    localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] ch;
    logic [7:0] cnt;
    logic [3:0] samples;

    logic dwell_end;
    logic last_ch;

    assign dwell_end = (cnt == 8'd0);
    assign last_ch   = (ch == 2'd3);

    // State register; reset aborts any scan immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start is only honoured from idle, so requests
    // arriving mid-scan or during the done cycle are dropped.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (bus.start)            state_next = ST_SCAN;
            ST_SCAN: if (dwell_end && last_ch) state_next = ST_DONE;
            ST_DONE: state_next = CONT ? ST_SCAN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Channel, dwell counter and sample capture; sample bits are only written
    // on their own sample edge so untouched bits keep the previous scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch      <= 2'd0;
            cnt     <= 8'd0;
            samples <= 4'b0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    ch  <= 2'd0;
                    cnt <= bus.start ? DWELL_LAST : 8'd0;
                end
                ST_SCAN: begin
                    if (!dwell_end) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        samples[ch] <= bus.mux_out;
                        if (!last_ch) begin
                            ch  <= ch + 2'd1;
                            cnt <= DWELL_LAST;
                        end
                    end
                end
                ST_DONE: begin
                    ch  <= 2'd0;
                    cnt <= CONT ? DWELL_LAST : 8'd0;
                end
                default: begin
                    ch  <= 2'd0;
                    cnt <= 8'd0;
                end
            endcase
        end
    end

    // Outputs decode registered state only, so nothing is combinational
    // from the inputs.
    always_comb begin
        bus.s1      = ch[1];
        bus.s2      = ch[0];
        bus.busy    = (state == ST_SCAN);
        bus.done    = (state == ST_DONE);
        bus.samples = samples;
    end

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Bench for mux_channel_scanner: a table of single-scan vectors plus
// hand-written sequences for reset, start-held and continuous scanning.
module tb_mux_channel_scanner;

    typedef struct {
        logic [3:0] mux_in;
        logic [3:0] exp_samples;
        bit         repulse;
    } scan_vec_t;

    logic       clk;
    logic       rst_n;
    logic       start1;
    logic       start2;
    logic [3:0] mux_in;
    logic [3:0] exp_smp [2];

    int compared;
    int mismatched;
    int busy_cycles;

    scan_vec_t vecs [4];

    mux_channel_scanner_if if1 ();
    mux_channel_scanner_if if2 ();

    assign if1.start   = start1;
    assign if2.start   = start2;
    assign if1.mux_out = mux_in[{if1.s1, if1.s2}];
    assign if2.mux_out = mux_in[{if2.s1, if2.s2}];

    mux_channel_scanner #(.DWELL(4), .CONT(1'b0)) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1)
    );

    mux_channel_scanner #(.DWELL(2), .CONT(1'b1)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int n,
                               input logic [7:0] act, input logic [7:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at edge %0d: got %0h, expected %0h", name, n, act, exp);
        end
    endtask

    task automatic checkAll(input int dut, input int n, input logic [1:0] e_ch,
                            input logic e_busy, input logic e_done, input logic [3:0] e_smp);
        logic [1:0] a_ch;
        logic       a_busy;
        logic       a_done;
        logic [3:0] a_smp;
        if (dut == 0) begin
            a_ch = {if1.s1, if1.s2}; a_busy = if1.busy; a_done = if1.done; a_smp = if1.samples;
        end else begin
            a_ch = {if2.s1, if2.s2}; a_busy = if2.busy; a_done = if2.done; a_smp = if2.samples;
        end
        checkOutput($sformatf("dut%0d.ch", dut + 1),      n, 8'(a_ch),   8'(e_ch));
        checkOutput($sformatf("dut%0d.busy", dut + 1),    n, 8'(a_busy), 8'(e_busy));
        checkOutput($sformatf("dut%0d.done", dut + 1),    n, 8'(a_done), 8'(e_done));
        checkOutput($sformatf("dut%0d.samples", dut + 1), n, 8'(a_smp),  8'(e_smp));
        if (a_busy === 1'b1) busy_cycles++;
    endtask

    // Runs num_edges clock edges starting at a negedge; edge 0 is the first
    // posedge and sees start high. Expected values come from the scan timing
    // model: a period of 4*dwell scan edges, one done edge and (without
    // continuous mode) one idle edge.
    task automatic applyStimulus(input int dut, input int num_edges, input int dwell,
                                 input bit cont, input bit hold_start, input bit repulse,
                                 input int flip_edge, input int flip_bit);
        int         period;
        int         p;
        int         idx;
        logic       drive;
        logic [1:0] e_ch;
        logic       e_busy;
        logic       e_done;
        period      = cont ? (4 * dwell + 1) : (4 * dwell + 2);
        busy_cycles = 0;
        for (int n = 0; n < num_edges; n++) begin
            drive = hold_start || (n == 0) || (repulse && (n == 3 || n == 9));
            if (dut == 0) start1 = drive;
            else          start2 = drive;
            if (n == flip_edge) mux_in[flip_bit] = ~mux_in[flip_bit];
            @(posedge clk);
            p = n % period;
            if (p >= dwell && p <= 4 * dwell && (p % dwell) == 0) begin
                idx = p / dwell - 1;
                exp_smp[dut][idx] = mux_in[idx];
            end
            @(negedge clk);
            if (p < 4 * dwell) begin
                e_ch = 2'(p / dwell); e_busy = 1'b1; e_done = 1'b0;
            end else if (p == 4 * dwell) begin
                e_ch = 2'd3;          e_busy = 1'b0; e_done = 1'b1;
            end else begin
                e_ch = 2'd0;          e_busy = 1'b0; e_done = 1'b0;
            end
            checkAll(dut, n, e_ch, e_busy, e_done, exp_smp[dut]);
        end
        if (dut == 0) start1 = 1'b0;
        else          start2 = 1'b0;
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        start1     = 1'b0;
        start2     = 1'b0;
        mux_in     = 4'b0000;
        exp_smp[0] = 4'b0000;
        exp_smp[1] = 4'b0000;
        rst_n      = 1'b0;

        // mux_in bit i is the mux input Ii
        vecs[0] = '{mux_in: 4'b0101, exp_samples: 4'b0101, repulse: 1'b0};
        vecs[1] = '{mux_in: 4'b1110, exp_samples: 4'b1110, repulse: 1'b0};
        vecs[2] = '{mux_in: 4'b0011, exp_samples: 4'b0011, repulse: 1'b1};
        vecs[3] = '{mux_in: 4'b1001, exp_samples: 4'b1001, repulse: 1'b0};

        #12;
        checkAll(0, -1, 2'd0, 1'b0, 1'b0, 4'b0000);
        checkAll(1, -1, 2'd0, 1'b0, 1'b0, 4'b0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Single scans, including one with start re-pulsed mid-scan
        for (int v = 0; v < 3; v++) begin
            mux_in = vecs[v].mux_in;
            applyStimulus(0, 18, 4, 1'b0, 1'b0, vecs[v].repulse, -1, 0);
            checkOutput("table.samples", v, 8'(if1.samples), 8'(vecs[v].exp_samples));
            checkOutput("table.busy_cycles", v, 8'(busy_cycles), 8'd16);
        end

        // Reset mid-scan clears everything without a clock edge
        mux_in = 4'b1111;
        applyStimulus(0, 7, 4, 1'b0, 1'b0, 1'b0, -1, 0);
        #2 rst_n = 1'b0;
        #1;
        checkAll(0, -1, 2'd0, 1'b0, 1'b0, 4'b0000);
        exp_smp[0] = 4'b0000;
        exp_smp[1] = 4'b0000;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        mux_in = vecs[3].mux_in;
        applyStimulus(0, 18, 4, 1'b0, 1'b0, 1'b0, -1, 0);
        checkOutput("after_reset.samples", 0, 8'(if1.samples), 8'(vecs[3].exp_samples));

        // Start held high: back-to-back scans, I2 flipped during the second
        mux_in = 4'b1011;
        applyStimulus(0, 36, 4, 1'b0, 1'b1, 1'b0, 20, 2);
        checkOutput("held.samples", 0, 8'(if1.samples), 8'(4'b1111));

        // Continuous mode, dwell 2: done every 9 edges
        mux_in = 4'b0110;
        applyStimulus(1, 28, 2, 1'b1, 1'b0, 1'b0, -1, 0);
        checkOutput("cont.samples", 0, 8'(if2.samples), 8'(4'b0110));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
